// File: rtl/raw_window_3x3_gen.sv
// 3x6 RAW window generator placed after the two cascaded demosaic line buffers.
// Each accepted beat carries 4 pixels for the current line and the same column
// of the two previous lines. A beat is held until its right neighbour is known,
// then emitted with left/right neighbours (edge-replicated at line ends) and
// Bayer phase plus frame/line markers.
module raw_window_3x3_gen #(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_tuser,
    input  logic        I_valid,
    input  logic [32:0] I_data_r0,
    input  logic [32:0] I_data_r1,
    input  logic [32:0] I_data_r2,
    output logic        O_valid,
    output logic [47:0] O_win0,
    output logic [47:0] O_win1,
    output logic [47:0] O_win2,
    output logic        O_flag,
    output logic        O_col_odd,
    output logic        O_row_odd,
    output logic        O_sof,
    output logic        O_eol,
    output logic        O_eof
);

    localparam int W4 = IMG_WIDTH / 4;
    localparam int CW = (W4 > 1) ? $clog2(W4) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(W4 - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Extract pixel idx (0 = leftmost) from a 33-bit beat.
    function automatic logic [7:0] pix(input logic [32:0] beat, input int idx);
        return beat[idx*8 +: 8];
    endfunction

    // Assemble a 6-pixel window row: right neighbour in the top byte, left in the bottom.
    function automatic logic [47:0] build_win(input logic [32:0] beat,
                                              input logic [7:0]  left,
                                              input logic [7:0]  right);
        return {right, beat[31:0], left};
    endfunction

    logic [32:0]   in_beat_s [3];
    logic [32:0]   hold_r    [3];
    logic [7:0]    left_r    [3];
    logic          hold_v_r;
    logic [CW-1:0] hold_col_r;
    logic [RW-1:0] hold_row_r;
    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;

    logic          flush_s;
    logic          emit_mid_s;
    logic          emit_s;
    logic [CW-1:0] in_col_s;
    logic [RW-1:0] in_row_s;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;
    logic          hold_v_nxt_s;
    logic [47:0]   win_s     [3];

    assign in_beat_s[0] = I_data_r0;
    assign in_beat_s[1] = I_data_r1;
    assign in_beat_s[2] = I_data_r2;

    // Emission decision, beat position bookkeeping and window assembly.
    always_comb begin
        flush_s      = 1'b0;
        emit_mid_s   = 1'b0;
        emit_s       = 1'b0;
        in_col_s     = col_r;
        in_row_s     = row_r;
        col_nxt_s    = col_r;
        row_nxt_s    = row_r;
        hold_v_nxt_s = hold_v_r;
        for (int i = 0; i < 3; i++) begin
            win_s[i] = 48'h0;
        end

        // A last-of-line beat never waits; a mid-line beat waits for its right
        // neighbour and is dropped if a frame start arrives first.
        flush_s    = hold_v_r && (hold_col_r == COL_LAST);
        emit_mid_s = hold_v_r && (hold_col_r != COL_LAST) && I_valid && !I_tuser;
        emit_s     = flush_s || emit_mid_s;

        if (I_tuser) begin
            in_col_s = '0;
            in_row_s = '0;
        end else begin
            in_col_s = col_r;
            in_row_s = row_r;
        end

        if (I_valid) begin
            if (in_col_s == COL_LAST) begin
                col_nxt_s = '0;
                if (in_row_s == ROW_LAST) begin
                    row_nxt_s = '0;
                end else begin
                    row_nxt_s = in_row_s + RW'(1);
                end
            end else begin
                col_nxt_s = in_col_s + CW'(1);
                row_nxt_s = in_row_s;
            end
        end else begin
            col_nxt_s = in_col_s;
            row_nxt_s = in_row_s;
        end

        if (I_valid) begin
            hold_v_nxt_s = 1'b1;
        end else if (flush_s || I_tuser) begin
            hold_v_nxt_s = 1'b0;
        end else begin
            hold_v_nxt_s = hold_v_r;
        end

        for (int i = 0; i < 3; i++) begin
            logic [7:0] lft;
            logic [7:0] rgt;
            if (hold_col_r != '0) begin
                lft = left_r[i];
            end else begin
                lft = pix(hold_r[i], 0);
            end
            if (flush_s) begin
                rgt = pix(hold_r[i], 3);
            end else begin
                rgt = pix(in_beat_s[i], 0);
            end
            win_s[i] = build_win(hold_r[i], lft, rgt);
        end
    end

    // Hold register, left-neighbour registers and beat position counters.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hold_v_r   <= 1'b0;
            hold_col_r <= '0;
            hold_row_r <= '0;
            col_r      <= '0;
            row_r      <= '0;
            for (int i = 0; i < 3; i++) begin
                hold_r[i] <= 33'h0;
                left_r[i] <= 8'h0;
            end
        end else begin
            hold_v_r <= hold_v_nxt_s;
            col_r    <= col_nxt_s;
            row_r    <= row_nxt_s;
            if (I_valid) begin
                hold_col_r <= in_col_s;
                hold_row_r <= in_row_s;
                for (int i = 0; i < 3; i++) begin
                    hold_r[i] <= in_beat_s[i];
                    if (hold_v_r) begin
                        left_r[i] <= pix(hold_r[i], 3);
                    end
                end
            end
        end
    end

    // Registered window outputs; data holds between emissions, markers pulse.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_valid   <= 1'b0;
            O_win0    <= 48'h0;
            O_win1    <= 48'h0;
            O_win2    <= 48'h0;
            O_flag    <= 1'b0;
            O_col_odd <= 1'b0;
            O_row_odd <= 1'b0;
            O_sof     <= 1'b0;
            O_eol     <= 1'b0;
            O_eof     <= 1'b0;
        end else begin
            O_valid   <= emit_s;
            O_col_odd <= 1'b0;
            O_sof     <= emit_s && (hold_row_r == '0) && (hold_col_r == '0);
            O_eol     <= flush_s;
            O_eof     <= flush_s && (hold_row_r == ROW_LAST);
            if (emit_s) begin
                O_win0    <= win_s[0];
                O_win1    <= win_s[1];
                O_win2    <= win_s[2];
                O_flag    <= hold_r[0][32];
                O_row_odd <= hold_row_r[0];
            end
        end
    end

endmodule

// File: tb/tb_raw_window_3x3_gen.sv
// Bench for raw_window_3x3_gen: directed cases plus randomized beats checked
// against a beat-level reference model with expected emission cycles.
module tb_raw_window_3x3_gen;

    localparam int IMG_WIDTH  = 16;
    localparam int IMG_HEIGHT = 4;
    localparam int W4         = IMG_WIDTH / 4;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_tuser;
    logic        I_valid;
    logic [32:0] I_data_r0;
    logic [32:0] I_data_r1;
    logic [32:0] I_data_r2;
    logic        O_valid;
    logic [47:0] O_win0;
    logic [47:0] O_win1;
    logic [47:0] O_win2;
    logic        O_flag;
    logic        O_col_odd;
    logic        O_row_odd;
    logic        O_sof;
    logic        O_eol;
    logic        O_eof;

    raw_window_3x3_gen #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_tuser(I_tuser), .I_valid(I_valid),
        .I_data_r0(I_data_r0), .I_data_r1(I_data_r1), .I_data_r2(I_data_r2),
        .O_valid(O_valid), .O_win0(O_win0), .O_win1(O_win1), .O_win2(O_win2),
        .O_flag(O_flag), .O_col_odd(O_col_odd), .O_row_odd(O_row_odd),
        .O_sof(O_sof), .O_eol(O_eol), .O_eof(O_eof)
    );

    typedef struct {
        logic [47:0] w0, w1, w2;
        logic        flag, row_odd, sof, eol, eof;
        int          cyc;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_valid = 0;

    exp_t        q[$];
    logic [47:0] obs_w0[$];
    logic [47:0] obs_w1[$];
    logic        obs_sof[$];
    logic        obs_eol[$];
    logic        obs_eof[$];
    logic        obs_rodd[$];

    // reference model state (beat level)
    int                m_col = 0;
    int                m_row = 0;
    logic              p_v   = 1'b0;
    logic [2:0][32:0]  p_beat;
    logic [2:0][7:0]   p_left;
    int                p_col, p_row;
    logic [2:0][7:0]   last_p3;

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    always @(posedge I_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input logic [2:0][32:0] b, input logic [2:0][7:0] lf,
                                      input logic [2:0][7:0] rt, input int col, input int row,
                                      input int when);
        exp_t e;
        e.w0      = {rt[0], b[0][31:24], b[0][23:16], b[0][15:8], b[0][7:0], lf[0]};
        e.w1      = {rt[1], b[1][31:24], b[1][23:16], b[1][15:8], b[1][7:0], lf[1]};
        e.w2      = {rt[2], b[2][31:24], b[2][23:16], b[2][15:8], b[2][7:0], lf[2]};
        e.flag    = b[0][32];
        e.row_odd = (row % 2) == 1;
        e.sof     = (row == 0) && (col == 0);
        e.eol     = (col == W4 - 1);
        e.eof     = (col == W4 - 1) && (row == IMG_HEIGHT - 1);
        e.cyc     = when;
        return e;
    endfunction

    // Present one cycle of input and update the reference model.
    task automatic drive(input logic v, input logic t, input logic [32:0] d0,
                         input logic [32:0] d1, input logic [32:0] d2);
        logic [2:0][32:0] nb;
        logic [2:0][7:0]  lf, rt;
        I_valid = v; I_tuser = t;
        I_data_r0 = d0; I_data_r1 = d1; I_data_r2 = d2;
        nb = {d2, d1, d0};
        if (t) begin
            p_v = 1'b0; m_col = 0; m_row = 0;
        end
        if (v) begin
            if (p_v) begin
                for (int r = 0; r < 3; r++) rt[r] = nb[r][7:0];
                q.push_back(make_exp(p_beat, p_left, rt, p_col, p_row, cyc + 1));
            end
            for (int r = 0; r < 3; r++) begin
                lf[r] = (m_col == 0) ? nb[r][7:0] : last_p3[r];
                last_p3[r] = nb[r][31:24];
            end
            if (m_col == W4 - 1) begin
                for (int r = 0; r < 3; r++) rt[r] = nb[r][31:24];
                q.push_back(make_exp(nb, lf, rt, m_col, m_row, cyc + 2));
                p_v = 1'b0;
            end else begin
                p_v = 1'b1; p_beat = nb; p_left = lf; p_col = m_col; p_row = m_row;
            end
            m_col++;
            if (m_col == W4) begin
                m_col = 0;
                m_row = (m_row + 1) % IMG_HEIGHT;
            end
        end
        @(posedge I_clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 33'h0, 33'h0, 33'h0);
    endtask

    function automatic logic [32:0] seq_beat(input int base, input int k);
        logic [32:0] b;
        b[7:0]   = 8'(base + 4*k);
        b[15:8]  = 8'(base + 4*k + 1);
        b[23:16] = 8'(base + 4*k + 2);
        b[31:24] = 8'(base + 4*k + 3);
        b[32]    = 1'(k % 2);
        return b;
    endfunction

    task automatic send_seq(input int base, input int k, input logic t);
        drive(1'b1, t, seq_beat(base, k), seq_beat(base + 64, k), seq_beat(base + 128, k));
    endtask

    task automatic clear_obs();
        obs_w0.delete(); obs_w1.delete(); obs_sof.delete();
        obs_eol.delete(); obs_eof.delete(); obs_rodd.delete();
        n_valid = 0;
    endtask

    task automatic do_reset(input int n);
        I_rst_n = 1'b0; I_valid = 1'b0; I_tuser = 1'b0;
        q.delete(); p_v = 1'b0; m_col = 0; m_row = 0;
        repeat (n) @(posedge I_clk);
        #1 I_rst_n = 1'b1;
        clear_obs();
    endtask

    // Output monitor: reset values, scoreboard compare and emission timing.
    always @(negedge I_clk) begin
        if (!I_rst_n) begin
            check_val("reset_outputs",
                      {54'h0, O_valid, O_flag, O_col_odd, O_row_odd, O_sof, O_eol, O_eof,
                       |O_win0, |O_win1, |O_win2}, 64'h0);
        end else if (O_valid) begin
            exp_t e;
            n_valid++;
            obs_w0.push_back(O_win0); obs_w1.push_back(O_win1);
            obs_sof.push_back(O_sof); obs_eol.push_back(O_eol);
            obs_eof.push_back(O_eof); obs_rodd.push_back(O_row_odd);
            if (q.size() == 0) begin
                check_val("spurious_valid", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check_val("win0", 64'(O_win0), 64'(e.w0));
                check_val("win1", 64'(O_win1), 64'(e.w1));
                check_val("win2", 64'(O_win2), 64'(e.w2));
                check_val("flag", 64'(O_flag), 64'(e.flag));
                check_val("col_odd", 64'(O_col_odd), 64'd0);
                check_val("row_odd", 64'(O_row_odd), 64'(e.row_odd));
                check_val("sof", 64'(O_sof), 64'(e.sof));
                check_val("eol", 64'(O_eol), 64'(e.eol));
                check_val("eof", 64'(O_eof), 64'(e.eof));
                check_val("emit_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
            check_val("missed_emit", 64'(cyc), 64'(q[0].cyc));
            void'(q.pop_front());
        end
    end

    initial begin
        int sof_cnt, eof_cnt;
        logic v, t;
        I_rst_n = 1'b0; I_valid = 1'b0; I_tuser = 1'b0;
        I_data_r0 = 33'h0; I_data_r1 = 33'h0; I_data_r2 = 33'h0;
        last_p3 = '0;
        @(posedge I_clk); #1;
        do_reset(3);

        // one line, continuous valid
        for (int k = 0; k < W4; k++) send_seq(0, k, k == 0);
        idle(4);
        check_val("line_count", 64'(n_valid), 64'd4);
        check_val("line_w0_0", 64'(obs_w0[0]), 64'h04_03_02_01_00_00);
        check_val("line_w0_1", 64'(obs_w0[1]), 64'h08_07_06_05_04_03);
        check_val("line_w0_2", 64'(obs_w0[2]), 64'h0C_0B_0A_09_08_07);
        check_val("line_w0_3", 64'(obs_w0[3]), 64'h0F_0F_0E_0D_0C_0B);
        check_val("line_w1_0", 64'(obs_w1[0]), 64'h44_43_42_41_40_40);
        check_val("line_eol_3", 64'(obs_eol[3]), 64'd1);
        sof_cnt = 0;
        foreach (obs_sof[i]) sof_cnt += int'(obs_sof[i]);
        check_val("line_sof0", 64'(obs_sof[0]), 64'd1);
        check_val("line_sof_cnt", 64'(sof_cnt), 64'd1);
        clear_obs();

        // same line with a 3-cycle gap between beats 1 and 2
        send_seq(0, 0, 1'b1); send_seq(0, 1, 1'b0);
        idle(3);
        send_seq(0, 2, 1'b0); send_seq(0, 3, 1'b0);
        idle(4);
        check_val("gap_count", 64'(n_valid), 64'd4);
        check_val("gap_w0_1", 64'(obs_w0[1]), 64'h08_07_06_05_04_03);
        clear_obs();

        // full frame, back-to-back lines
        for (int k = 0; k < W4 * IMG_HEIGHT; k++) send_seq(0, k, k == 0);
        idle(4);
        check_val("frame_count", 64'(n_valid), 64'd16);
        eof_cnt = 0;
        foreach (obs_eof[i]) eof_cnt += int'(obs_eof[i]);
        check_val("frame_eof_cnt", 64'(eof_cnt), 64'd1);
        check_val("frame_eof_last", 64'(obs_eof[15]), 64'd1);
        check_val("frame_rodd_l1", 64'(obs_rodd[4]), 64'd1);
        check_val("frame_rodd_l2", 64'(obs_rodd[8]), 64'd0);
        clear_obs();

        // frame start mid-line while col 2 is held
        send_seq(0, 0, 1'b1); send_seq(0, 1, 1'b0); send_seq(0, 2, 1'b0);
        for (int k = 0; k < W4; k++) send_seq(100, k, k == 0);
        idle(4);
        check_val("tuser_count", 64'(n_valid), 64'd6);
        check_val("tuser_new_w0", 64'(obs_w0[2]), 64'h68_67_66_65_64_64);
        check_val("tuser_new_sof", 64'(obs_sof[2]), 64'd1);
        clear_obs();

        // reset during line 2, then a fresh line without frame start
        for (int k = 0; k < W4 + 2; k++) send_seq(0, k, k == 0);
        do_reset(3);
        for (int k = 0; k < W4; k++) send_seq(32, k, 1'b0);
        idle(4);
        check_val("rst_count", 64'(n_valid), 64'd4);
        check_val("rst_first_w0", 64'(obs_w0[0]), 64'h24_23_22_21_20_20);
        check_val("rst_first_sof", 64'(obs_sof[0]), 64'd1);
        clear_obs();

        // randomized beats, gaps and frame starts
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 39) == 0);
            drive(v, t, {1'($urandom_range(0, 1)), 32'($urandom)},
                        {1'($urandom_range(0, 1)), 32'($urandom)},
                        {1'($urandom_range(0, 1)), 32'($urandom)});
        end
        while (m_col != 0)
            drive(1'b1, 1'b0, {1'b1, 32'($urandom)}, {1'b0, 32'($urandom)}, {1'b1, 32'($urandom)});
        idle(4);
        check_val("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
